// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the EX stage: ALU operation codes, the EX
// sequencer state type and the memory-operation classifier.
package riscv_pkg;

    localparam logic [4:0] ALU_LW    = 5'd0;
    localparam logic [4:0] ALU_LUI   = 5'd1;
    localparam logic [4:0] ALU_AUIPC = 5'd2;
    localparam logic [4:0] ALU_SLL   = 5'd3;
    localparam logic [4:0] ALU_SRL   = 5'd4;
    localparam logic [4:0] ALU_SRA   = 5'd5;
    localparam logic [4:0] ALU_SLT   = 5'd6;
    localparam logic [4:0] ALU_SLTU  = 5'd7;
    localparam logic [4:0] ALU_XOR   = 5'd8;
    localparam logic [4:0] ALU_OR    = 5'd9;
    localparam logic [4:0] ALU_AND   = 5'd10;
    localparam logic [4:0] ALU_SB    = 5'd11;
    localparam logic [4:0] ALU_SH    = 5'd12;
    localparam logic [4:0] ALU_SW    = 5'd13;
    localparam logic [4:0] ALU_ADD   = 5'd14;
    localparam logic [4:0] ALU_SUB   = 5'd15;
    localparam logic [4:0] ALU_SLLI  = 5'd16;
    localparam logic [4:0] ALU_SRLI  = 5'd17;
    localparam logic [4:0] ALU_SRAI  = 5'd18;
    localparam logic [4:0] ALU_SLTI  = 5'd19;
    localparam logic [4:0] ALU_SLTIU = 5'd20;
    localparam logic [4:0] ALU_XORI  = 5'd21;
    localparam logic [4:0] ALU_ORI   = 5'd22;
    localparam logic [4:0] ALU_ANDI  = 5'd23;
    localparam logic [4:0] ALU_ADDI  = 5'd24;
    localparam logic [4:0] ALU_BEQ   = 5'd25;
    localparam logic [4:0] ALU_BNE   = 5'd26;
    localparam logic [4:0] ALU_BLT   = 5'd27;
    localparam logic [4:0] ALU_BGE   = 5'd28;
    localparam logic [4:0] ALU_BLTU  = 5'd29;
    localparam logic [4:0] ALU_BGEU  = 5'd30;
    localparam logic [4:0] ALU_JAL   = 5'd31;

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, ERR} ex_state_t;

    // Only loads and stores touch data memory and therefore hold the EX stage.
    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == ALU_LW) || (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

endpackage

// File: rtl/ex_flow_ctrl.sv
// EX-stage sequencer: owns the PC, handshakes with ID, holds for data memory
// and flushes younger instructions after a taken branch or jump.
module ex_flow_ctrl
    import riscv_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              FLUSH_DEPTH = 2,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_alu_operation,
    input  logic            ex_branch_flag,
    input  logic            ex_jump_flag,
    input  logic [PC_W-1:0] ex_aluout,
    input  logic [PC_W-1:0] ex_jump_addr,
    output logic            mem_req,
    input  logic            mem_ready,
    output logic            ex_fire,
    output logic            flush,
    output logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            mem_err
);

    localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
    localparam bit              HAS_FLUSH = (FLUSH_DEPTH > 0);
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_DEPTH - 1);
    localparam logic [7:0]      WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    ex_state_t       r_state;
    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_flushCnt;
    logic [7:0]      r_waitCnt;
    logic            r_memReq;
    logic            r_flush;
    logic            r_memErr;

    logic w_isMem;
    logic w_redirect;
    logic w_runIssue;

    assign w_isMem    = is_mem_op(id_alu_operation);
    assign w_redirect = ex_jump_flag | ex_branch_flag;
    assign w_runIssue = (r_state == RUN) & id_valid & ~rst;

    assign id_ready = (r_state == RUN) & ~rst;
    assign stall    = (r_state == MEM_WAIT) & ~rst;
    assign ex_fire  = (w_runIssue & ~w_isMem) | ((r_state == MEM_WAIT) & mem_ready & ~rst);
    assign mem_req  = r_memReq;
    assign flush    = r_flush;
    assign pc       = r_pc;
    assign mem_err  = r_memErr;

    // Jump beats branch; memory ops ignore both flags and only advance the PC
    // once data memory answers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_flushCnt <= '0;
            r_waitCnt  <= '0;
            r_memReq   <= 1'b0;
            r_flush    <= 1'b0;
            r_memErr   <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (id_valid) begin
                        if (w_isMem) begin
                            r_state   <= MEM_WAIT;
                            r_memReq  <= 1'b1;
                            r_waitCnt <= '0;
                        end else begin
                            if (ex_jump_flag)        r_pc <= ex_jump_addr;
                            else if (ex_branch_flag) r_pc <= ex_aluout;
                            else                     r_pc <= r_pc + PC_ONE;
                            if (w_redirect && HAS_FLUSH) begin
                                r_state    <= FLUSH;
                                r_flush    <= 1'b1;
                                r_flushCnt <= FLUSH_INIT;
                            end
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_memReq <= 1'b0;
                        r_pc     <= r_pc + PC_ONE;
                        r_state  <= RUN;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        r_state  <= ERR;
                        r_memErr <= 1'b1;
                        r_memReq <= 1'b0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                FLUSH: begin
                    if (r_flushCnt == 3'd0) begin
                        r_flush <= 1'b0;
                        r_state <= RUN;
                    end else begin
                        r_flushCnt <= r_flushCnt - 3'd1;
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: r_state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_flow_ctrl.sv
// Randomized scoreboard bench for ex_flow_ctrl: a cycle-level behavioural
// model predicts outputs and commits, a negedge monitor compares them.
module tb_ex_flow_ctrl;

    localparam int          PC_W        = 32;
    localparam logic [31:0] RESET_PC    = 32'h10;
    localparam int          FLUSH_DEPTH = 2;
    localparam int          MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_alu_operation;
    logic        ex_branch_flag;
    logic        ex_jump_flag;
    logic [31:0] ex_aluout;
    logic [31:0] ex_jump_addr;
    logic        mem_req;
    logic        mem_ready;
    logic        ex_fire;
    logic        flush;
    logic        stall;
    logic [31:0] pc;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        bit idReady;
        bit fire;
        bit stall;
        bit flush;
        bit memReq;
        bit memErr;
    } snap_t;

    snap_t       expQ[$];
    logic [31:0] commitQ[$];

    // Behavioural model: pending memory age (-1 = none), remaining flush cycles.
    logic [31:0] mPc;
    bit          mErr;
    int          mFlushLeft;
    int          mMemAge;

    ex_flow_ctrl #(
        .PC_W(PC_W),
        .RESET_PC(RESET_PC),
        .FLUSH_DEPTH(FLUSH_DEPTH),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_alu_operation(id_alu_operation),
        .ex_branch_flag(ex_branch_flag),
        .ex_jump_flag(ex_jump_flag),
        .ex_aluout(ex_aluout),
        .ex_jump_addr(ex_jump_addr),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .ex_fire(ex_fire),
        .flush(flush),
        .stall(stall),
        .pc(pc),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isMemOp(input logic [4:0] op);
        return op == 5'd0 || op == 5'd11 || op == 5'd12 || op == 5'd13;
    endfunction

    task automatic modelReset();
        mPc        = RESET_PC;
        mErr       = 1'b0;
        mFlushLeft = 0;
        mMemAge    = -1;
    endtask

    // Drive one cycle, record the predicted response, advance the model, then
    // move to just after the next rising edge.
    task automatic applyStimulus(input bit rstv, input bit valid, input logic [4:0] op,
                                 input bit br, input bit jmp, input logic [31:0] alu,
                                 input logic [31:0] ja, input bit rdy);
        snap_t s;
        bit inRun;
        rst              = rstv;
        id_valid         = valid;
        id_alu_operation = op;
        ex_branch_flag   = br;
        ex_jump_flag     = jmp;
        ex_aluout        = alu;
        ex_jump_addr     = ja;
        mem_ready        = rdy;

        inRun     = !mErr && mFlushLeft == 0 && mMemAge < 0;
        s.pc      = mPc;
        s.idReady = inRun && !rstv;
        s.stall   = mMemAge >= 0 && !rstv;
        s.flush   = mFlushLeft > 0;
        s.memReq  = mMemAge >= 0;
        s.memErr  = mErr;
        s.fire    = !rstv && ((inRun && valid && !isMemOp(op)) || (mMemAge >= 0 && rdy));
        expQ.push_back(s);
        if (s.fire) commitQ.push_back(mPc);

        if (rstv) begin
            modelReset();
        end else if (inRun && valid) begin
            if (isMemOp(op)) begin
                mMemAge = 0;
            end else begin
                mPc = jmp ? ja : (br ? alu : mPc + 32'd1);
                if (jmp || br) mFlushLeft = FLUSH_DEPTH;
            end
        end else if (mMemAge >= 0) begin
            if (rdy) begin
                mPc     = mPc + 32'd1;
                mMemAge = -1;
            end else if (mMemAge + 1 >= MEM_TIMEOUT) begin
                mErr    = 1'b1;
                mMemAge = -1;
            end else begin
                mMemAge++;
            end
        end else if (mFlushLeft > 0) begin
            mFlushLeft--;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit valid, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, valid, 5'd14, 0, 0, 32'h0, 32'h0, rdy);
    endtask

    task automatic jumpTo(input logic [31:0] target);
        applyStimulus(0, 1, 5'd31, 0, 1, 32'h0, target, 0);
        idle(FLUSH_DEPTH, 1, 0);
    endtask

    always @(negedge clk) begin
        snap_t e;
        logic [31:0] cpc;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc", pc, e.pc);
            checkOutput("id_ready", 32'(id_ready), 32'(e.idReady));
            checkOutput("ex_fire", 32'(ex_fire), 32'(e.fire));
            checkOutput("stall", 32'(stall), 32'(e.stall));
            checkOutput("flush", 32'(flush), 32'(e.flush));
            checkOutput("mem_req", 32'(mem_req), 32'(e.memReq));
            checkOutput("mem_err", 32'(mem_err), 32'(e.memErr));
            if (ex_fire === 1'b1) begin
                if (commitQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL commit actual=unexpected_fire required=no_fire at %0t", $time);
                end else begin
                    cpc = commitQ.pop_front();
                    checkOutput("commit_pc", pc, cpc);
                end
            end
        end
    end

    initial begin
        int rdyMode;
        logic [4:0] op;
        rst = 1'b1; id_valid = 0; id_alu_operation = '0; ex_branch_flag = 0;
        ex_jump_flag = 0; ex_aluout = '0; ex_jump_addr = '0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        idle(1, 0, 0);
        applyStimulus(1, 1, 5'd14, 0, 0, 32'h0, 32'h0, 1);
        idle(3, 1, 0);

        jumpTo(32'h20);
        applyStimulus(0, 1, 5'd25, 1, 0, 32'h40, 32'h0, 0);
        idle(FLUSH_DEPTH + 1, 1, 0);
        jumpTo(32'h20);
        applyStimulus(0, 1, 5'd25, 0, 0, 32'h40, 32'h0, 0);
        idle(1, 0, 0);

        applyStimulus(0, 1, 5'd31, 1, 1, 32'h50, 32'h80, 0);
        idle(FLUSH_DEPTH + 1, 0, 0);

        jumpTo(32'h5);
        applyStimulus(0, 1, 5'd0, 1, 1, 32'h99, 32'h77, 0);
        idle(2, 1, 0);
        idle(1, 1, 1);
        idle(1, 0, 0);

        applyStimulus(0, 1, 5'd13, 0, 0, 32'h0, 32'h0, 0);
        idle(MEM_TIMEOUT + 3, 1, 0);
        idle(2, 1, 1);
        applyStimulus(1, 0, 5'd14, 0, 0, 32'h0, 32'h0, 0);
        idle(1, 0, 0);

        applyStimulus(0, 1, 5'd31, 0, 1, 32'h0, 32'h30, 0);
        applyStimulus(1, 1, 5'd14, 0, 0, 32'h0, 32'h0, 0);
        idle(2, 0, 0);

        jumpTo(32'hFFFF_FFFF);
        idle(2, 1, 0);

        rdyMode = 1;
        for (int i = 0; i < 800; i++) begin
            if (i % 64 == 0) rdyMode = $urandom_range(0, 2);
            op = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(11, 13)))
                                             : 5'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, op,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          $urandom, $urandom,
                          rdyMode != 0 && $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("exp_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("commit_queue_drained", 32'(commitQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
